ob_table_cnt_seq: RTL

Sequencer for the order-book table count engine. Accepts one price-count command at a time, drives the CSA count datapath through ceil(N/(CSA_DEGREE_N-2)) accumulation rounds, and returns the accumulated quantity over a valid/ready response channel. It sits between the order-book command pipeline and the count datapath. It restarts the count when the table is modified mid-count, within a bounded restart budget, so that it always makes forward progress.

---
 rtl/bcd_pkg.sv | 4 +
 rtl/ob_pkg.sv | 4 +
 rtl/ob_table_cnt_seq_if.sv | 34 +++
 rtl/ob_table_cnt_seq.sv | 112 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - BCD price types shared by the order-book blocks
package bcd_pkg;
  typedef logic [15:0] price_t;  // four packed BCD digits
endpackage

// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - order-book quantity types
package ob_pkg;
  typedef logic [31:0] accum_quantity_t;
endpackage

// File: rtl/ob_table_cnt_seq_if.sv
// rtl/ob_table_cnt_seq_if.sv - command, datapath and response signals of the count sequencer
interface ob_table_cnt_seq_if #(
  parameter int ROUNDS = 3
);
  logic                    cmd_vld;
  logic                    cmd_rdy;
  bcd_pkg::price_t         cmd_price;
  logic                    cmd_is_ask;
  bcd_pkg::price_t         eng_price;
  logic                    eng_is_ask;
  logic [ROUNDS-1:0]       eng_sel;
  logic                    eng_acc_clr;
  logic                    eng_acc_en;
  ob_pkg::accum_quantity_t eng_sum;
  logic                    tbl_upd;
  logic                    rsp_vld;
  logic                    rsp_rdy;
  ob_pkg::accum_quantity_t rsp_quantity;
  logic                    rsp_stale;
  logic                    busy;

  // slave is the sequencer; master is the command/datapath/response side around it
  modport slave (
    input  cmd_vld, cmd_price, cmd_is_ask, eng_sum, tbl_upd, rsp_rdy,
    output cmd_rdy, eng_price, eng_is_ask, eng_sel, eng_acc_clr, eng_acc_en,
           rsp_vld, rsp_quantity, rsp_stale, busy
  );

  modport master (
    output cmd_vld, cmd_price, cmd_is_ask, eng_sum, tbl_upd, rsp_rdy,
    input  cmd_rdy, eng_price, eng_is_ask, eng_sel, eng_acc_clr, eng_acc_en,
           rsp_vld, rsp_quantity, rsp_stale, busy
  );
endinterface

// File: rtl/ob_table_cnt_seq.sv
// rtl/ob_table_cnt_seq.sv - order-book table count sequencer: one command at a time,
// ROUNDS accumulation rounds, restart on table update within a bounded budget.
module ob_table_cnt_seq #(
  parameter int N            = 16,
  parameter int CSA_DEGREE_N = 8,
  parameter int MAX_RESTART  = 3
) (
  input  logic               clk,
  input  logic               rst,
  ob_table_cnt_seq_if.slave  bus
);
  localparam int L      = CSA_DEGREE_N - 2;
  localparam int ROUNDS = (N + L - 1) / L;
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [RW-1:0]     LAST_RND = RW'(ROUNDS - 1);
  localparam logic [3:0]        RCNT_MAX = 4'(MAX_RESTART);
  localparam logic [ROUNDS-1:0] SEL_ONE  = ROUNDS'(1);

  typedef enum logic [1:0] {IDLE, CLR, ACC, RSP} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [RW-1:0]           rnd;
  logic [3:0]              rcnt;
  bcd_pkg::price_t         price_q;
  logic                    is_ask_q;
  ob_pkg::accum_quantity_t quantity_q;
  logic                    stale_q;

  logic last_rnd;
  logic restart;

  assign last_rnd = (rnd == LAST_RND);
  // a table write mid-count restarts only while budget remains; restart beats completion
  assign restart  = bus.tbl_upd && (rcnt < RCNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.cmd_rdy     = 1'b0;
    bus.busy        = 1'b1;
    bus.rsp_vld     = 1'b0;
    bus.eng_acc_clr = 1'b0;
    bus.eng_acc_en  = 1'b0;
    bus.eng_sel     = '0;
    case (state)
      IDLE: begin
        bus.cmd_rdy = 1'b1;
        bus.busy    = 1'b0;
        if (bus.cmd_vld) state_nx = CLR;
      end
      CLR: begin
        bus.eng_acc_clr = 1'b1;
        state_nx        = ACC;
      end
      ACC: begin
        bus.eng_acc_en = 1'b1;
        bus.eng_sel    = SEL_ONE << rnd;
        if (restart)       state_nx = CLR;
        else if (last_rnd) state_nx = RSP;
      end
      RSP: begin
        bus.rsp_vld = 1'b1;
        if (bus.rsp_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd        <= '0;
      rcnt       <= '0;
      price_q    <= '0;
      is_ask_q   <= 1'b0;
      quantity_q <= '0;
      stale_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_vld) begin
            price_q  <= bus.cmd_price;
            is_ask_q <= bus.cmd_is_ask;
            rcnt     <= '0;
            stale_q  <= 1'b0;
          end
        end
        CLR: rnd <= '0;
        ACC: begin
          if (restart) begin
            rcnt <= rcnt + 4'd1;
          end else begin
            if (bus.tbl_upd) stale_q <= 1'b1;
            if (last_rnd) quantity_q <= bus.eng_sum;
            else          rnd        <= rnd + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.eng_price    = price_q;
  assign bus.eng_is_ask   = is_ask_q;
  assign bus.rsp_quantity = quantity_q;
  assign bus.rsp_stale    = stale_q;
endmodule
